// File: rtl/apb_grgpio.sv
// apb_grgpio: APB-slave general-purpose I/O port, up to 32 bits.
// Holds output/direction/interrupt registers with OR/AND/XOR write aliases,
// a two-flop pin synchroniser and a single registered interrupt line.
// Optional feature: define GPIO_PULSE_EN to add the per-bit output toggle
// (pulse) register at offset 0x4C.
module apb_grgpio #(
  parameter int          nbits = 8,
  parameter logic [31:0] imask = 32'h0,
  parameter bit          oepol = 1'b0
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        apbi_psel,
  input  logic        apbi_penable,
  input  logic [31:0] apbi_paddr,
  input  logic        apbi_pwrite,
  input  logic [31:0] apbi_pwdata,
  output logic [31:0] apbo_prdata,
  output logic        apbo_pirq,
  input  logic [31:0] gpioi_din,
  output logic [31:0] gpioo_dout,
  output logic [31:0] gpioo_oen,
  output logic [31:0] gpioo_val
);

  // Implemented bits, and the subset that may raise an interrupt.
  localparam logic [31:0] wmask     = (nbits >= 32) ? 32'hFFFF_FFFF
                                                    : ((32'd1 << nbits) - 32'd1);
  localparam logic [31:0] imask_eff = wmask & imask;
  localparam logic [4:0]  nbits_m1  = 5'(nbits - 1);
`ifdef GPIO_PULSE_EN
  localparam logic        pulse_cap = 1'b1;
`else
  localparam logic        pulse_cap = 1'b0;
`endif

  typedef enum logic [2:0] {OP_NONE, OP_SET, OP_OR, OP_AND, OP_XOR} op_e;

  logic [31:0] out_q, dir_q, msk_q, pol_q, edg_q;
  logic [31:0] sync1_q, sync2_q, prev_q;
  logic [31:0] pulse_q;
  logic        pirq_q;

  logic        wr;
  logic [7:0]  off;
  op_e         out_op, dir_op, msk_op;
  logic        pol_we, edg_we;
  logic [31:0] req, level_hit, edge_hit;
  logic        unused_addr;

  assign wr          = apbi_psel & apbi_penable & apbi_pwrite;
  assign off         = {apbi_paddr[7:2], 2'b00};
  assign unused_addr = ^{apbi_paddr[31:8], apbi_paddr[1:0]};

  // Apply a plain write or a logic alias to a register, keeping only writable bits.
  function automatic logic [31:0] apply(op_e op, logic [31:0] cur,
                                        logic [31:0] wd, logic [31:0] m);
    logic [31:0] res;
    res = cur;
    case (op)
      OP_SET:  res = wd & m;
      OP_OR:   res = (cur | wd) & m;
      OP_AND:  res = cur & wd;
      OP_XOR:  res = (cur ^ wd) & m;
      default: res = cur;
    endcase
    return res;
  endfunction

  // Decode the write address into per-register operations.
`ifdef GPIO_PULSE_EN
  logic pls_we;
`endif
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    out_op = OP_NONE;
    dir_op = OP_NONE;
    msk_op = OP_NONE;
    pol_we = 1'b0;
    edg_we = 1'b0;
`ifdef GPIO_PULSE_EN
    pls_we = 1'b0;
`endif
    if (wr) begin
      case (off)
        8'h04: out_op = OP_SET;
        8'h08: dir_op = OP_SET;
        8'h0C: msk_op = OP_SET;
        8'h10: pol_we = 1'b1;
        8'h14: edg_we = 1'b1;
`ifdef GPIO_PULSE_EN
        8'h4C: pls_we = 1'b1;
`endif
        8'h54: out_op = OP_OR;
        8'h58: dir_op = OP_OR;
        8'h5C: msk_op = OP_OR;
        8'h64: out_op = OP_AND;
        8'h68: dir_op = OP_AND;
        8'h6C: msk_op = OP_AND;
        8'h74: out_op = OP_XOR;
        8'h78: dir_op = OP_XOR;
        8'h7C: msk_op = OP_XOR;
        default: ;
      endcase
    end
  end

  // Register file; an output write wins over a concurrent pulse toggle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_q <= '0;
      dir_q <= '0;
      msk_q <= '0;
      pol_q <= '0;
      edg_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      out_q <= (out_op == OP_NONE) ? (out_q ^ pulse_q)
                                   : apply(out_op, out_q, apbi_pwdata, wmask);
      dir_q <= apply(dir_op, dir_q, apbi_pwdata, wmask);
      msk_q <= apply(msk_op, msk_q, apbi_pwdata, imask_eff);
      if (pol_we) pol_q <= apbi_pwdata & imask_eff;
      if (edg_we) edg_q <= apbi_pwdata & imask_eff;
    end
  end

`ifdef GPIO_PULSE_EN
  // Pulse register: each set bit toggles its output every clock.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)       pulse_q <= '0;
    else if (pls_we) pulse_q <= apbi_pwdata & wmask;
  end
`else
  assign pulse_q = '0;
`endif

  // Two-flop input synchroniser plus one history flop for edge detection.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
    end else begin
      sync1_q <= gpioi_din & wmask;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign level_hit = ~(sync2_q ^ pol_q);
  assign edge_hit  = level_hit & (prev_q ^ pol_q);
  assign req       = msk_q & ((edg_q & edge_hit) | (~edg_q & level_hit));

  // Registered OR of all per-bit interrupt requests.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) pirq_q <= 1'b0;
    else       pirq_q <= |req;
  end

  // Combinational read mux; aliases read back their target register.
  always_comb begin
    apbo_prdata = '0;
    if (apbi_psel) begin
      case (off)
        8'h00:                      apbo_prdata = sync2_q;
        8'h04, 8'h54, 8'h64, 8'h74: apbo_prdata = out_q;
        8'h08, 8'h58, 8'h68, 8'h78: apbo_prdata = dir_q;
        8'h0C, 8'h5C, 8'h6C, 8'h7C: apbo_prdata = msk_q;
        8'h10:                      apbo_prdata = pol_q;
        8'h14:                      apbo_prdata = edg_q;
        8'h18:                      apbo_prdata = {15'd0, pulse_cap, 11'd0, nbits_m1};
        8'h4C:                      apbo_prdata = pulse_q;
        default:                    apbo_prdata = '0;
      endcase
    end
  end

  // Unimplemented direction bits are 0, which maps to the inactive enable level.
  assign gpioo_dout = out_q;
  assign gpioo_val  = out_q;
  assign gpioo_oen  = dir_q ~^ {32{oepol}};
  assign apbo_pirq  = pirq_q;

endmodule

// File: tb/tb_apb_grgpio.sv
// tb_apb_grgpio: self-checking bench for apb_grgpio (nbits=8, imask=0xFF,
// oepol=0). Directed register/alias/interrupt sequences followed by random
// register traffic compared against a behavioural register-map model.
module tb_apb_grgpio;

  localparam int          NB  = 8;
  localparam logic [31:0] W   = 32'h0000_00FF;
  localparam logic [31:0] IMP = 32'h0000_00FF;
`ifdef GPIO_PULSE_EN
  localparam logic [31:0] PULSE_BIT = 32'h0001_0000;
`else
  localparam logic [31:0] PULSE_BIT = 32'h0;
`endif

  logic        clk = 1'b0;
  logic        rstn;
  logic        psel, penable, pwrite;
  logic [31:0] paddr, pwdata, prdata;
  logic        pirq;
  logic [31:0] din, dout, oen, val;

  int total = 0;
  int bad   = 0;

  // Reference model of the architectural registers.
  logic [31:0] m_out = '0, m_dir = '0, m_msk = '0, m_pol = '0, m_edg = '0;
  logic [31:0] m_pls = '0, m_din = '0;

  apb_grgpio #(.nbits(NB), .imask(IMP), .oepol(1'b0)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .apbi_psel    (psel),
    .apbi_penable (penable),
    .apbi_paddr   (paddr),
    .apbi_pwrite  (pwrite),
    .apbi_pwdata  (pwdata),
    .apbo_prdata  (prdata),
    .apbo_pirq    (pirq),
    .gpioi_din    (din),
    .gpioo_dout   (dout),
    .gpioo_oen    (oen),
    .gpioo_val    (val)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic void model_write(input logic [7:0] off, input logic [31:0] wd);
    case (off)
      8'h04: m_out = wd & W;
      8'h54: m_out = (m_out | wd) & W;
      8'h64: m_out = m_out & wd;
      8'h74: m_out = (m_out ^ wd) & W;
      8'h08: m_dir = wd & W;
      8'h58: m_dir = (m_dir | wd) & W;
      8'h68: m_dir = m_dir & wd;
      8'h78: m_dir = (m_dir ^ wd) & W;
      8'h0C: m_msk = wd & IMP;
      8'h5C: m_msk = (m_msk | wd) & IMP;
      8'h6C: m_msk = m_msk & wd;
      8'h7C: m_msk = (m_msk ^ wd) & IMP;
      8'h10: m_pol = wd & IMP;
      8'h14: m_edg = wd & IMP;
      8'h4C: if (PULSE_BIT != 0) m_pls = wd & W;
      default: ;
    endcase
  endfunction

  function automatic logic [31:0] model_read(input logic [7:0] off);
    case (off)
      8'h00:                      return m_din;
      8'h04, 8'h54, 8'h64, 8'h74: return m_out;
      8'h08, 8'h58, 8'h68, 8'h78: return m_dir;
      8'h0C, 8'h5C, 8'h6C, 8'h7C: return m_msk;
      8'h10:                      return m_pol;
      8'h14:                      return m_edg;
      8'h18:                      return 32'(NB - 1) | PULSE_BIT;
      8'h4C:                      return m_pls;
      default:                    return 32'h0;
    endcase
  endfunction

  // APB write; returns on the falling edge after the committing rising edge.
  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = addr; pwdata = data;
    @(negedge clk);
    penable = 1'b1;
    @(negedge clk);
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    model_write({addr[7:2], 2'b00}, data);
  endtask

  task automatic rd(input logic [31:0] addr, output logic [31:0] data);
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = addr;
    @(negedge clk);
    penable = 1'b1;
    #1 data = prdata;
    @(negedge clk);
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic check_pads(input string tag);
    check({tag, ".dout"}, dout, m_out);
    check({tag, ".val"},  val,  m_out);
    check({tag, ".oen"},  oen,  ~m_dir);
  endtask

  initial begin
    logic [31:0] r, ext;
    logic [7:0]  offs [$];
    logic        exp_b;

    rstn = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; din = '0;

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst.dout", dout, 32'h0);
    check("rst.oen",  oen,  32'hFFFF_FFFF);
    check("rst.pirq", {31'd0, pirq}, 32'h0);
    rstn = 1'b1;
    @(negedge clk);
    check("idle.prdata", prdata, 32'h0);
    rd(32'h08, r); check("rst.dir", r, 32'h0);
    rd(32'h18, r); check("cap", r, 32'h7 | PULSE_BIT);

    // Output drive.
    wr(32'h08, 32'hFF);
    for (int i = 0; i < 256; i++) begin
      wr(32'h04, 32'(i));
      check($sformatf("drive%0d.dout", i), dout, 32'(i));
      if (i % 64 == 0) check_pads($sformatf("drive%0d", i));
    end
    check("drive.oen", oen, 32'hFFFF_FF00);

    // Input read through the synchroniser; upper pins must read 0.
    wr(32'h08, 32'h0);
    check("indir.oen", oen, 32'hFFFF_FFFF);
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      din = {$urandom() >> 8, 8'(i)};
      m_din = din & W;
      repeat (3) @(negedge clk);
      rd(32'h00, r);
      check($sformatf("in%0d", i), r, 32'(i));
    end

    // Logic aliases.
    for (int i = 0; i < 256; i++) begin
      wr(32'h04, 32'h00); wr(32'h54, 32'(i));
      check($sformatf("or%0d", i), dout, 32'(i));
      wr(32'h04, 32'hFF); wr(32'h64, 32'(i));
      check($sformatf("and%0d", i), dout, 32'hFF & 32'(i));
      wr(32'h04, 32'hFF); wr(32'h74, 32'(i));
      check($sformatf("xor%0d", i), dout, 32'hFF ^ 32'(i));
    end

    // Edge interrupt on pin 0, rising.
    @(negedge clk); din = '0; m_din = '0;
    repeat (4) @(negedge clk);
    wr(32'h10, 32'h01); wr(32'h14, 32'h01); wr(32'h0C, 32'h01);
    repeat (3) @(negedge clk);
    check("edge.idle", {31'd0, pirq}, 32'h0);
    din = 32'h1; m_din = 32'h1;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      check($sformatf("edge.k%0d", k), {31'd0, pirq}, (k == 3) ? 32'h1 : 32'h0);
    end

    // Level interrupt on pin 0, active high.
    din = '0; m_din = '0;
    repeat (4) @(negedge clk);
    wr(32'h14, 32'h00);
    repeat (2) @(negedge clk);
    check("level.idle", {31'd0, pirq}, 32'h0);
    din = 32'h1; m_din = 32'h1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      check($sformatf("level.hi%0d", k), {31'd0, pirq}, (k >= 3) ? 32'h1 : 32'h0);
    end
    din = '0; m_din = '0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      check($sformatf("level.lo%0d", k), {31'd0, pirq}, (k < 3) ? 32'h1 : 32'h0);
    end
    wr(32'h0C, 32'h0);

`ifdef GPIO_PULSE_EN
    // Pulse toggling, write priority, then hold.
    wr(32'h04, 32'h0); wr(32'h4C, 32'h1);
    exp_b = 1'b0;
    check("pulse.start", {31'd0, dout[0]}, {31'd0, exp_b});
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      exp_b = ~exp_b;
      check($sformatf("pulse.tog%0d", k), {31'd0, dout[0]}, {31'd0, exp_b});
    end
    wr(32'h04, 32'h0);
    check("pulse.wrprio", {31'd0, dout[0]}, 32'h0);
    wr(32'h4C, 32'h0);
    exp_b = 1'b1;  // three toggles occur before the clear commits
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      check($sformatf("pulse.hold%0d", k), {31'd0, dout[0]}, {31'd0, exp_b});
    end
    wr(32'h04, 32'h0);
`else
    // Without the pulse feature 0x4C is inert.
    wr(32'h4C, 32'h1);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      check($sformatf("nopulse.hold%0d", k), dout, m_out);
    end
    rd(32'h4C, r); check("nopulse.rd", r, 32'h0);
`endif

    // Random register traffic against the model.
    offs = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h18, 8'h54, 8'h58,
             8'h5C, 8'h64, 8'h68, 8'h6C, 8'h74, 8'h78, 8'h7C, 8'h20, 8'h40,
             8'h50, 8'h60, 8'h70, 8'hFC};
    if (PULSE_BIT == 0) offs.push_back(8'h4C);
    for (int it = 0; it < 400; it++) begin
      int sel;
      logic [7:0] off;
      sel = int'($urandom_range(0, 9));
      off = offs[$urandom_range(0, offs.size() - 1)];
      ext = $urandom();
      if (sel <= 3) begin
        wr({ext[31:8], off[7:2], ext[1:0]}, $urandom());
        check_pads($sformatf("rnd%0d.w%02h", it, off));
      end else if (sel <= 7) begin
        rd({ext[31:8], off[7:2], ext[1:0]}, r);
        check($sformatf("rnd%0d.r%02h", it, off), r, model_read(off));
      end else begin
        @(negedge clk);
        din = $urandom();
        m_din = din & W;
        repeat (3) @(negedge clk);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
